// File: rtl/ifetch_queue_if.sv
// ifetch_queue_if: fetch-side and decode-side signals of the instruction-fetch queue.
// master = the fetch queue itself, slave = the surrounding memory / decode environment.
interface ifetch_queue_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  modport master (
    output imem_req, imem_addr, id_valid, id_instr, id_pc,
    input  imem_rdata, redirect, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req, imem_addr, id_valid, id_instr, id_pc,
    output imem_rdata, redirect, redirect_pc, id_ready
  );
endinterface

// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction-fetch front end feeding the IF/ID register.
// Issues word fetches, buffers {instr, pc} in a DEPTH-entry FIFO and hands one
// entry per cycle to decode. A redirect flushes the FIFO and drops the in-flight fetch.
// Optional feature macro: IFQ_STATS_EN adds flush_count / bubble_count outputs.
module ifetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOOP     = 32'h0000_0000
) (
  input  logic           clock,
  input  logic           reset,
  ifetch_queue_if.master bus
`ifdef IFQ_STATS_EN
  ,
  output logic [15:0]    flush_count,
  output logic [15:0]    bubble_count
`endif
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam int unsigned OW = CW + 1;
  localparam logic [OW-1:0] DEPTH_O = OW'(DEPTH);

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_r, state_s;
  logic [31:0]     fetch_pc_r, fetch_pc_s;
  logic            inflight_r, inflight_s;
  logic [31:0]     inflight_pc_r, inflight_pc_s;
  logic [CW-1:0]   count_r, count_s;
  logic [PW-1:0]   rd_ptr_r, rd_ptr_s;
  logic [PW-1:0]   wr_ptr_r, wr_ptr_s;
  logic [31:0]     mem_instr_r [DEPTH];
  logic [31:0]     mem_pc_r    [DEPTH];

  logic [OW-1:0]   occupancy_s;
  logic            issue_s;
  logic            push_s;
  logic            pop_s;
  logic            id_valid_s;
  logic [31:0]     id_instr_s;
  logic [31:0]     id_pc_s;

  assign id_valid_s = (count_r != {CW{1'b0}});

  // Control: FSM next state, issue decision (credit = queued + in-flight), push/pop qualification
  always_comb begin
    occupancy_s = {1'b0, count_r} + {{CW{1'b0}}, inflight_r};
    state_s     = state_r;
    issue_s     = 1'b0;
    push_s      = 1'b0;
    pop_s       = 1'b0;
    case (state_r)
      ST_BOOT: begin
        state_s = ST_RUN;
        issue_s = 1'b0;
      end
      ST_RUN: begin
        state_s = ST_RUN;
        if (!bus.redirect && (occupancy_s < DEPTH_O)) begin
          issue_s = 1'b1;
        end else begin
          issue_s = 1'b0;
        end
      end
      default: begin
        state_s = ST_BOOT;
        issue_s = 1'b0;
      end
    endcase
    if (bus.redirect) begin
      push_s = 1'b0;
      pop_s  = 1'b0;
    end else begin
      push_s = inflight_r;
      pop_s  = id_valid_s && bus.id_ready;
    end
  end

  // Datapath next state: redirect flush, FIFO occupancy/pointers, fetch PC and in-flight tracking
  always_comb begin
    count_s       = count_r;
    rd_ptr_s      = rd_ptr_r;
    wr_ptr_s      = wr_ptr_r;
    fetch_pc_s    = fetch_pc_r;
    inflight_s    = inflight_r;
    inflight_pc_s = inflight_pc_r;
    if (bus.redirect) begin
      count_s       = {CW{1'b0}};
      rd_ptr_s      = {PW{1'b0}};
      wr_ptr_s      = {PW{1'b0}};
      fetch_pc_s    = bus.redirect_pc & 32'hFFFF_FFFC;
      inflight_s    = 1'b0;
      inflight_pc_s = inflight_pc_r;
    end else begin
      case ({push_s, pop_s})
        2'b10:   count_s = count_r + CW'(1);
        2'b01:   count_s = count_r - CW'(1);
        default: count_s = count_r;
      endcase
      if (push_s) begin
        wr_ptr_s = wr_ptr_r + PW'(1);
      end else begin
        wr_ptr_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_s = rd_ptr_r + PW'(1);
      end else begin
        rd_ptr_s = rd_ptr_r;
      end
      if (issue_s) begin
        fetch_pc_s    = fetch_pc_r + 32'd4;
        inflight_s    = 1'b1;
        inflight_pc_s = fetch_pc_r;
      end else begin
        fetch_pc_s    = fetch_pc_r;
        inflight_s    = 1'b0;
        inflight_pc_s = inflight_pc_r;
      end
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r       <= ST_BOOT;
      fetch_pc_r    <= RESET_PC;
      inflight_r    <= 1'b0;
      inflight_pc_r <= 32'h0000_0000;
      count_r       <= {CW{1'b0}};
      rd_ptr_r      <= {PW{1'b0}};
      wr_ptr_r      <= {PW{1'b0}};
    end else begin
      state_r       <= state_s;
      fetch_pc_r    <= fetch_pc_s;
      inflight_r    <= inflight_s;
      inflight_pc_r <= inflight_pc_s;
      count_r       <= count_s;
      rd_ptr_r      <= rd_ptr_s;
      wr_ptr_r      <= wr_ptr_s;
    end
  end

  // FIFO storage: capture the returning word with the PC it was fetched from
  always_ff @(posedge clock) begin
    if (push_s) begin
      mem_instr_r[wr_ptr_r] <= bus.imem_rdata;
      mem_pc_r[wr_ptr_r]    <= inflight_pc_r;
    end
  end

  // Head presentation: NOOP and PC 0 while empty so decode sees a benign bubble
  always_comb begin
    id_instr_s = NOOP;
    id_pc_s    = 32'h0000_0000;
    if (id_valid_s) begin
      id_instr_s = mem_instr_r[rd_ptr_r];
      id_pc_s    = mem_pc_r[rd_ptr_r];
    end else begin
      id_instr_s = NOOP;
      id_pc_s    = 32'h0000_0000;
    end
  end

  assign bus.imem_req  = issue_s;
  assign bus.imem_addr = fetch_pc_r;
  assign bus.id_valid  = id_valid_s;
  assign bus.id_instr  = id_instr_s;
  assign bus.id_pc     = id_pc_s;

`ifdef IFQ_STATS_EN
  logic [15:0] flush_count_r;
  logic [15:0] bubble_count_r;

  // Saturating counters of redirect cycles and decode-starved RUN cycles
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      flush_count_r  <= 16'h0000;
      bubble_count_r <= 16'h0000;
    end else begin
      if (bus.redirect && (flush_count_r != 16'hFFFF)) begin
        flush_count_r <= flush_count_r + 16'd1;
      end
      if ((state_r == ST_RUN) && !id_valid_s && bus.id_ready &&
          (bubble_count_r != 16'hFFFF)) begin
        bubble_count_r <= bubble_count_r + 16'd1;
      end
    end
  end

  assign flush_count  = flush_count_r;
  assign bubble_count = bubble_count_r;
`endif

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: table-driven vectors plus a scoreboard of expected {pc, instr}
// entries built from the fetch stream; hand sequences cover redirect and reset corners.
module tb_ifetch_queue;

  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  ifetch_queue_if bus();

`ifdef IFQ_STATS_EN
  logic [15:0] flush_count;
  logic [15:0] bubble_count;
`endif

  ifetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000), .NOOP(32'h0000_0000)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus)
`ifdef IFQ_STATS_EN
    ,
    .flush_count  (flush_count),
    .bubble_count (bubble_count)
`endif
  );

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;

  typedef struct {
    logic        rdy;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  ent_t        sb[$];
  vec_t        tbl[19];
  logic        m_run;
  logic        m_infl;
  logic [31:0] m_infl_pc;
  logic [31:0] m_fetch;
  logic        pend_v;
  logic [31:0] pend_a;
  logic        s_req, s_valid;
  logic [31:0] s_addr, s_pc;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ 32'hC0DE_0001;
  endfunction

  function automatic vec_t mk(input logic rdy, input logic req, input logic [31:0] addr,
                              input logic valid, input logic [31:0] pc);
    vec_t v;
    v.rdy = rdy; v.exp_req = req; v.exp_addr = addr; v.exp_valid = valid; v.exp_pc = pc;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    sb.delete();
    m_run = 1'b0; m_infl = 1'b0; m_infl_pc = 32'h0; m_fetch = 32'h0;
    pend_v = 1'b0; pend_a = 32'h0;
  endtask

  task automatic apply_reset();
    @(negedge clock);
    reset = 1'b1;
    bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.id_ready = 1'b0;
    bus.imem_rdata = 32'hBAD0_BAD0;
    model_reset();
    repeat (2) @(negedge clock);
    @(posedge clock);
    #2 reset = 1'b0;
  endtask

  // One clock: drive inputs, sample at negedge+1, check against model, advance model.
  task automatic cycle(input logic rdr, input logic [31:0] rpc, input logic rdy);
    logic exp_req;
    int   occ;
    @(negedge clock);
    bus.redirect = rdr; bus.redirect_pc = rpc; bus.id_ready = rdy;
    bus.imem_rdata = pend_v ? word(pend_a) : 32'hBAD0_BAD0;
    #1;
    s_req = bus.imem_req; s_addr = bus.imem_addr; s_valid = bus.id_valid; s_pc = bus.id_pc;
    occ = sb.size() + (m_infl ? 1 : 0);
    exp_req = m_run && !rdr && (occ < 4);
    check32("imem_req", bus.imem_req, exp_req);
    if (exp_req) check32("imem_addr", bus.imem_addr, m_fetch);
    check32("id_valid", bus.id_valid, sb.size() != 0);
    if (sb.size() != 0) begin
      check32("id_pc", bus.id_pc, sb[0].pc);
      check32("id_instr", bus.id_instr, sb[0].instr);
    end else begin
      check32("id_pc_empty", bus.id_pc, 32'h0);
      check32("id_instr_noop", bus.id_instr, 32'h0);
    end
    pend_v = bus.imem_req; pend_a = bus.imem_addr;
    if (rdr) begin
      sb.delete();
      m_infl = 1'b0;
      m_fetch = rpc & 32'hFFFF_FFFC;
    end else begin
      if ((sb.size() != 0) && rdy) void'(sb.pop_front());
      if (m_infl) sb.push_back('{pc: m_infl_pc, instr: word(m_infl_pc)});
      if (exp_req) begin
        m_infl = 1'b1; m_infl_pc = m_fetch; m_fetch = m_fetch + 32'd4;
      end else begin
        m_infl = 1'b0;
      end
    end
    m_run = 1'b1;
  endtask

  task automatic run_tbl(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) begin
      cycle(1'b0, 32'h0, tbl[i].rdy);
      check32($sformatf("tbl%0d_req", i), s_req, tbl[i].exp_req);
      if (tbl[i].exp_req) check32($sformatf("tbl%0d_addr", i), s_addr, tbl[i].exp_addr);
      check32($sformatf("tbl%0d_valid", i), s_valid, tbl[i].exp_valid);
      if (tbl[i].exp_valid) check32($sformatf("tbl%0d_pc", i), s_pc, tbl[i].exp_pc);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    // T1: ready high, one new fetch and one new head per cycle after 4-cycle latency
    tbl[0]  = mk(1'b1, 1'b0, 32'h00, 1'b0, 32'h00);
    tbl[1]  = mk(1'b1, 1'b1, 32'h00, 1'b0, 32'h00);
    tbl[2]  = mk(1'b1, 1'b1, 32'h04, 1'b0, 32'h00);
    tbl[3]  = mk(1'b1, 1'b1, 32'h08, 1'b1, 32'h00);
    tbl[4]  = mk(1'b1, 1'b1, 32'h0C, 1'b1, 32'h04);
    tbl[5]  = mk(1'b1, 1'b1, 32'h10, 1'b1, 32'h08);
    tbl[6]  = mk(1'b1, 1'b1, 32'h14, 1'b1, 32'h0C);
    // T2: ready low fills exactly DEPTH, then drains in order and resumes at 0x10
    tbl[7]  = mk(1'b0, 1'b0, 32'h00, 1'b0, 32'h00);
    tbl[8]  = mk(1'b0, 1'b1, 32'h00, 1'b0, 32'h00);
    tbl[9]  = mk(1'b0, 1'b1, 32'h04, 1'b0, 32'h00);
    tbl[10] = mk(1'b0, 1'b1, 32'h08, 1'b1, 32'h00);
    tbl[11] = mk(1'b0, 1'b1, 32'h0C, 1'b1, 32'h00);
    tbl[12] = mk(1'b0, 1'b0, 32'h00, 1'b1, 32'h00);
    tbl[13] = mk(1'b0, 1'b0, 32'h00, 1'b1, 32'h00);
    tbl[14] = mk(1'b1, 1'b0, 32'h00, 1'b1, 32'h00);
    tbl[15] = mk(1'b1, 1'b1, 32'h10, 1'b1, 32'h04);
    tbl[16] = mk(1'b1, 1'b1, 32'h14, 1'b1, 32'h08);
    tbl[17] = mk(1'b1, 1'b1, 32'h18, 1'b1, 32'h0C);
    tbl[18] = mk(1'b1, 1'b1, 32'h1C, 1'b1, 32'h10);

    bus.redirect = 1'b0; bus.redirect_pc = 32'h0; bus.id_ready = 1'b0;
    bus.imem_rdata = 32'hBAD0_BAD0;
    reset = 1'b1;
    model_reset();
    #1;
    check32("rst_req", bus.imem_req, 32'h0);
    check32("rst_addr", bus.imem_addr, 32'h0);
    check32("rst_valid", bus.id_valid, 32'h0);
    check32("rst_instr", bus.id_instr, 32'h0);

    apply_reset();
    run_tbl(0, 6);
    apply_reset();
    run_tbl(7, 18);

    // T3: redirect to 0x43 with 3 queued + 1 in flight
    apply_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h43, 1'b0);
    cycle(1'b0, 32'h0, 1'b1);
    check32("t3_req", s_req, 32'h1);
    check32("t3_addr", s_addr, 32'h40);
    cycle(1'b0, 32'h0, 1'b1);
    check32("t3_valid_early", s_valid, 32'h0);
    cycle(1'b0, 32'h0, 1'b1);
    check32("t3_valid", s_valid, 32'h1);
    check32("t3_pc", s_pc, 32'h40);
    for (int i = 0; i < 4; i++) cycle(1'b0, 32'h0, 1'b1);

    // T4: back-to-back redirects, last one wins
    cycle(1'b1, 32'h100, 1'b1);
    cycle(1'b1, 32'h200, 1'b1);
    check32("t4_noissue", s_req, 32'h0);
    cycle(1'b0, 32'h0, 1'b1);
    check32("t4_addr", s_addr, 32'h200);
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 32'h0, 1'b1);
      check32("t4_no_0x100", (s_valid && (s_pc >= 32'h100) && (s_pc < 32'h200)), 32'h0);
      if (i == 1) check32("t4_first_pc", s_pc, 32'h200);
    end

    // T5: asynchronous reset with a full queue
    for (int i = 0; i < 8; i++) cycle(1'b0, 32'h0, 1'b0);
    check32("t5_pre_valid", s_valid, 32'h1);
    @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check32("t5_async_valid", bus.id_valid, 32'h0);
    check32("t5_async_req", bus.imem_req, 32'h0);
    check32("t5_async_pc", bus.id_pc, 32'h0);
    check32("t5_async_addr", bus.imem_addr, 32'h0);
    model_reset();
    bus.id_ready = 1'b1;
    @(posedge clock);
    #2 reset = 1'b0;
    run_tbl(0, 4);

    // T6: redirect to top of address space, fetch wraps to 0
    apply_reset();
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b1, 32'hFFFF_FFFF, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    check32("t6_addr_top", s_addr, 32'hFFFF_FFFC);
    cycle(1'b0, 32'h0, 1'b1);
    check32("t6_addr_wrap", s_addr, 32'h0);
    cycle(1'b0, 32'h0, 1'b1);
    check32("t6_pc_top", s_pc, 32'hFFFF_FFFC);
`ifdef IFQ_STATS_EN
    check32("t6_flush_count", flush_count, 32'h1);
    check32("t6_bubble_count", bubble_count, 32'h3);
`endif
    cycle(1'b0, 32'h0, 1'b1);
    check32("t6_pc_wrap", s_pc, 32'h0);
    cycle(1'b0, 32'h0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
